serial_sample_bridge: RTL

SERIAL_SAMPLE_BRIDGE -- requirements
Module: serial_sample_bridge

---
 rtl/serial_pkg.sv | 28 ++
 rtl/sample_byte_mux.sv | 54 +++++
 rtl/serial_sample_bridge.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and width helpers for serial_sample_bridge
//
// Purpose: holds the bridge FSM state type and the derivations of the channel
//          select width and the per-channel byte count, so that the top and the
//          byte mux agree on them.
// Ports:   none (package).
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  // Frame byte index width: the longest frame is one echo byte plus four
  // data bytes (DATA_W = 32), i.e. indices 0..4.
  localparam int IDX_W = 3;

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int num_bytes(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/sample_byte_mux.sv
// rtl/sample_byte_mux.sv - selects the frame byte for a channel from the sample snapshot
//
// Purpose: maps (snapshot, channel, frame byte index) to the byte to transmit.
//          With ECHO set, index 0 is the channel command byte; the following
//          indices are the channel sample, least-significant byte first, with
//          the bits above DATA_W in the last byte forced to zero.
// Ports:   snapshot  in  NUM_CH*DATA_W  captured sample bus
//          ch        in  CH_W           channel to read
//          idx       in  IDX_W          byte position within the channel frame
//          byte_out  out 8              selected byte (combinational)
module sample_byte_mux
  import serial_pkg::*;
#(
  parameter int          NUM_CH    = 3,
  parameter int          DATA_W    = 16,
  parameter int          ECHO      = 1,
  parameter logic [7:0]  BASE_CHAR = 8'd120
) (
  input  logic [NUM_CH*DATA_W-1:0]    snapshot,
  input  logic [ch_width(NUM_CH)-1:0] ch,
  input  logic [IDX_W-1:0]            idx,
  output logic [7:0]                  byte_out
);

  localparam int CH_W   = ch_width(NUM_CH);
  localparam int NBYTES = num_bytes(DATA_W);
  localparam int PAD_W  = NBYTES * 8;
  localparam int DOFS   = (ECHO != 0) ? 1 : 0;

  logic [DATA_W-1:0] sample;
  logic [PAD_W-1:0]  padded;

  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CH_W'(k)) sample = snapshot[k*DATA_W +: DATA_W];
    end
  end

  // Zero-extension supplies the cleared upper bits of a partial last byte.
  assign padded = PAD_W'(sample);

  always_comb begin
    byte_out = '0;
    if (DOFS == 1 && idx == '0) begin
      byte_out = BASE_CHAR + 8'(ch);
    end else begin
      for (int b = 0; b < NBYTES; b++) begin
        if (idx == IDX_W'(b + DOFS)) byte_out = padded[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/serial_sample_bridge.sv
// rtl/serial_sample_bridge.sv - UART command to sample-frame bridge
//
// Purpose: a received command byte selects one channel (BASE_CHAR+k) or all
//          channels (ALL_CHAR); the sample bus is snapshotted on acceptance and
//          each channel is sent as an optional echo byte followed by its sample
//          bytes, LSB first, handshaking each byte with the UART transmitter.
// Ports:   CLK_50         in   1              clock (rising edge)
//          areset         in   1              asynchronous active-high reset
//          rx_data_ready  in   1              received-byte strobe
//          rx_data        in   8              received command byte
//          tx_busy        in   1              transmitter busy
//          sample_bus     in   NUM_CH*DATA_W  live channel samples
//          tx_start       out  1              one-cycle transmit request
//          tx_data        out  8              byte to transmit
//          ch_sel         out  CH_W           channel being sent
//          busy           out  1              frame in progress
//          overrun        out  1              sticky: command dropped while busy
module serial_sample_bridge
  import serial_pkg::*;
#(
  parameter int         NUM_CH    = 3,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] BASE_CHAR = 8'd120,
  parameter logic [7:0] ALL_CHAR  = 8'd97,
  parameter int         ECHO      = 1
) (
  input  logic                        CLK_50,
  input  logic                        areset,
  input  logic                        rx_data_ready,
  input  logic [7:0]                  rx_data,
  input  logic                        tx_busy,
  input  logic [NUM_CH*DATA_W-1:0]    sample_bus,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  output logic [ch_width(NUM_CH)-1:0] ch_sel,
  output logic                        busy,
  output logic                        overrun
);

  localparam int CH_W      = ch_width(NUM_CH);
  localparam int NBYTES    = num_bytes(DATA_W);
  localparam int FRAME_LEN = NBYTES + ((ECHO != 0) ? 1 : 0);

  state_t                     state;
  logic [NUM_CH*DATA_W-1:0]   snapshot;
  logic                       all_mode;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 mux_byte;
  logic [8:0]                 rel;
  logic                       is_ch_cmd;
  logic                       is_all_cmd;
  logic                       cmd_valid;

  // 9-bit difference so that bytes below BASE_CHAR cannot wrap into range.
  assign rel        = {1'b0, rx_data} - {1'b0, BASE_CHAR};
  assign is_ch_cmd  = (rx_data >= BASE_CHAR) && (rel < 9'(NUM_CH));
  assign is_all_cmd = (rx_data == ALL_CHAR);
  assign cmd_valid  = is_ch_cmd || is_all_cmd;
  assign busy       = (state != ST_IDLE);

  sample_byte_mux #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .ECHO     (ECHO),
    .BASE_CHAR(BASE_CHAR)
  ) u_mux (
    .snapshot(snapshot),
    .ch      (ch_sel),
    .idx     (idx),
    .byte_out(mux_byte)
  );

  always_ff @(posedge CLK_50 or posedge areset) begin
    if (areset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ch_sel   <= '0;
      overrun  <= 1'b0;
      snapshot <= '0;
      all_mode <= 1'b0;
      idx      <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_data_ready && cmd_valid) begin
            snapshot <= sample_bus;
            idx      <= '0;
            state    <= ST_SEND;
            // A channel command wins should ALL_CHAR ever overlap the channel range.
            if (is_ch_cmd) begin
              ch_sel   <= rel[CH_W-1:0];
              all_mode <= 1'b0;
            end else begin
              ch_sel   <= '0;
              all_mode <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= mux_byte;
            state    <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (tx_busy) state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (idx != IDX_W'(FRAME_LEN - 1)) begin
              idx   <= idx + 1'b1;
              state <= ST_SEND;
            end else if (all_mode && ch_sel != CH_W'(NUM_CH - 1)) begin
              ch_sel <= ch_sel + 1'b1;
              idx    <= '0;
              state  <= ST_SEND;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (state != ST_IDLE && rx_data_ready && cmd_valid) overrun <= 1'b1;
    end
  end

endmodule
